// File: rtl/ifid_block.sv
// rtl/ifid_block.sv - instruction fetch stage with IF/ID pipeline register and one-entry skid buffer
module ifid_block #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] OutPC,
  output logic [31:0] Inst,
  output logic        InstValid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic [31:0] pc_plus4;

  // 32-bit modulo increment; wraps from FFFF_FFFC to 0 naturally
  assign pc_plus4 = pc + 32'd4;

  // Request only while fetching; reset kills any in-flight request immediately
  assign ImemReq  = RSTN && (state == FETCH);
  assign ImemAddr = pc;

  // Fetch FSM, PC, skid buffer and IF/ID register in one registered process
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      buf_pc    <= 32'h0;
      buf_inst  <= NOP_INST;
      OutPC     <= 32'h0;
      Inst      <= NOP_INST;
      InstValid <= 1'b0;
    end else if (Redirect) begin
      // Redirect beats stall and drops any same-cycle response and buffered data
      state     <= FETCH;
      pc        <= {RedirectPC[31:2], 2'b00};
      buf_pc    <= 32'h0;
      buf_inst  <= NOP_INST;
      OutPC     <= RedirectPC;
      Inst      <= NOP_INST;
      InstValid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (ImemReady) begin
            pc <= pc_plus4;
            if (Stall) begin
              // IF/ID is frozen, so park the response until the stall clears
              buf_pc   <= pc;
              buf_inst <= ImemData;
              state    <= HOLD;
            end else begin
              OutPC     <= pc;
              Inst      <= ImemData;
              InstValid <= 1'b1;
            end
          end else if (!Stall) begin
            // Memory not ready: push a bubble, retry the same address
            OutPC     <= pc;
            Inst      <= NOP_INST;
            InstValid <= 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            // PC already points past the buffered instruction
            OutPC     <= buf_pc;
            Inst      <= buf_inst;
            InstValid <= 1'b1;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/ifid_block.md
# ifid_block

Instruction-fetch stage plus IF/ID pipeline register. Owns the program counter and drives a single-request instruction-memory handshake. Presents `OutPC`/`Inst` to the ID/EX block, which consumes them as its `InPC`/`Inst` inputs. Supports hazard stall and EX-stage redirect (branch/jal) with flush.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on reset, flush or empty fetch.
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RSTN`  in  1  reset, asynchronous assert, active-low.
- `ImemReq`  out  1  fetch request valid.
- `ImemAddr`  out  32  fetch address; equals the PC register.
- `ImemReady`  in  1  same-cycle response valid for `ImemAddr`.
- `ImemData`  in  32  fetched instruction, valid when `ImemReady`=1.
- `Stall`  in  1  hazard stall; IF/ID must hold.
- `Redirect`  in  1  taken branch/jal from EX; flush and reload PC.
- `RedirectPC`  in  32  new PC; bits [1:0] ignored (forced 00).
- `OutPC`  out  32  PC of instruction in IF/ID, to ID/EX `InPC`.
- `Inst`  out  32  instruction in IF/ID, to ID/EX `Inst`.
- `InstValid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- State machine, 2 states: FETCH, HOLD (one-entry skid buffer `BufInst`/`BufPC` full).
- FETCH: `ImemReq`=1, `ImemAddr`=PC.
  - `ImemReady`=1, `Stall`=0: IF/ID <= {PC, `ImemData`, valid=1}; PC <= PC+4; stay FETCH.
  - `ImemReady`=1, `Stall`=1: buffer <= {PC, `ImemData`}; PC <= PC+4; IF/ID unchanged; go HOLD.
  - `ImemReady`=0, `Stall`=0: IF/ID <= {PC, `NOP_INST`, valid=0} (bubble); PC unchanged.
  - `ImemReady`=0, `Stall`=1: everything holds.
- HOLD: `ImemReq`=0.
  - `Stall`=1: hold.
  - `Stall`=0: IF/ID <= {`BufPC`, `BufInst`, valid=1}; go FETCH (PC already advanced).
- `Redirect`=1 has the highest priority in any state, regardless of `Stall`:
  - PC <= {`RedirectPC`[31:2], 2'b00}; IF/ID <= {`RedirectPC`, `NOP_INST`, valid=0}; buffer discarded; next state FETCH.
  - Any same-cycle `ImemReady` data is dropped.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No misalignment trap.
- Reset (`RSTN`=0, asynchronous):
  - PC=`RESET_PC`, state=FETCH, buffer empty.
  - `OutPC`=0, `Inst`=`NOP_INST`, `InstValid`=0.
  - `ImemReq` forced 0 combinationally while `RSTN`=0.
- Reset asserted mid-fetch or mid-HOLD abandons the request and buffered data; no response is later consumed.

## Timing
- `ImemAddr` comes straight from the PC register; no combinational path from `ImemData` to any output.
- Fetch latency is 1 cycle: `ImemReady` at cycle t puts the instruction on `Inst`/`InstValid` after edge t+1.
- Redirect at cycle t: `ImemAddr`=`RedirectPC` at t+1; if ready at t+1, the target instruction is in IF/ID at t+2. Exactly one bubble is inserted.
- Stall release from HOLD: buffered instruction appears one edge after `Stall` falls; the next fetch issues that same cycle.
- Sustained throughput with `ImemReady`=1 and no stall: one instruction per cycle, PC sequence +4 each cycle.
- First `ImemReq`=1 occurs in the first cycle after `RSTN` deasserts.

## Test plan
- Reset: RSTN=0 mid-run -> immediately `ImemReq`=0, `InstValid`=0, `Inst`=32'h13. Release with ImemReady=1 -> `ImemAddr` sequence 0,4,8; `OutPC` 0,4,8 one cycle later.
- Memory wait: ImemReady low 3 cycles at addr 0x10 -> 3 bubbles (valid=0, `Inst`=32'h13), `ImemAddr` held at 0x10; then ready with data 0xABCD -> `Inst`=0xABCD, `OutPC`=0x10.
- Stall with response: Stall=1 while ImemReady returns 0x1234 at 0x20 -> IF/ID unchanged, `ImemReq`=0 next cycle. Drop Stall -> `Inst`=0x1234, `OutPC`=0x20, next `ImemAddr`=0x24.
- Redirect: Redirect=1, RedirectPC=0x103 during fetch of 0x40 (ready=1) -> 0x40 data dropped, `InstValid`=0, next `ImemAddr`=0x100.
- Redirect during HOLD with Stall=1 -> buffer discarded, state FETCH, `ImemAddr`=RedirectPC, no buffered instruction ever appears.
- Wrap: RESET_PC=32'hFFFF_FFF8, always ready -> `ImemAddr` FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
